// File: rtl/exu_pkg.sv
// Shared opcode encodings, FSM state type and op classification for the
// multi-cycle execute unit.
package exu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;
  localparam logic [3:0] OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_REMU = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_iterative(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/exu_muldiv.sv
// Iterative engine: radix-2 shift-add multiply and restoring unsigned divide,
// one bit per cycle for XLEN cycles; done is raised on the final iteration.
module exu_muldiv
  import exu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  logic            run_q, run_d;
  logic            is_div_q, is_div_d;
  logic            is_rem_q, is_rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  // acc: partial product (mul) or partial remainder (div)
  // opa: shifted multiplicand (mul) or dividend/quotient shifter (div)
  // opb: multiplier bits (mul) or divisor (div)
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] opa_q, opa_d;
  logic [XLEN-1:0] opb_q, opb_d;

  logic [XLEN-1:0] step_acc, step_opa, step_opb;
  logic [XLEN:0]   rem_sh, rem_diff;
  logic            last;

  always_comb begin
    rem_sh   = {acc_q, opa_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, opb_q};
    if (is_div_q) begin
      // A clear borrow bit means the shifted remainder covers the divisor.
      if (!rem_diff[XLEN]) begin
        step_acc = rem_diff[XLEN-1:0];
        step_opa = {opa_q[XLEN-2:0], 1'b1};
      end else begin
        step_acc = rem_sh[XLEN-1:0];
        step_opa = {opa_q[XLEN-2:0], 1'b0};
      end
      step_opb = opb_q;
    end else begin
      step_acc = acc_q + (opb_q[0] ? opa_q : '0);
      step_opa = opa_q << 1;
      step_opb = opb_q >> 1;
    end
  end

  assign last   = run_q && (cnt_q == CW'(XLEN - 1));
  assign done   = last && !flush;
  assign result = (is_div_q && !is_rem_q) ? step_opa : step_acc;

  always_comb begin
    run_d    = run_q;
    is_div_d = is_div_q;
    is_rem_d = is_rem_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    if (flush) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (start) begin
      run_d    = 1'b1;
      is_div_d = (op == OP_DIVU) || (op == OP_REMU);
      is_rem_d = (op == OP_REMU);
      cnt_d    = '0;
      acc_d    = '0;
      opa_d    = a;
      opb_d    = b;
    end else if (run_q) begin
      acc_d = step_acc;
      opa_d = step_opa;
      opb_d = step_opb;
      cnt_d = cnt_q + CW'(1);
      if (last) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q    <= 1'b0;
      is_div_q <= 1'b0;
      is_rem_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
    end else begin
      run_q    <= run_d;
      is_div_q <= is_div_d;
      is_rem_q <= is_rem_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
    end
  end

endmodule

// File: rtl/exu_mc.sv
// Multi-cycle execute unit: handshake FSM, single-cycle ALU datapath and the
// registered result; mul/divu/remu are delegated to exu_muldiv.
module exu_mc
  import exu_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_out,
  output logic            busy
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] alu_out_q, alu_out_d;

  logic                   accept;
  logic                   div_zero;
  logic                   iter_start;
  logic [SHW-1:0]         shamt;
  logic signed [XLEN-1:0] rs1_s, rs2_s;
  logic [XLEN-1:0]        sc_result;
  logic                   md_done;
  logic [XLEN-1:0]        md_result;

  assign accept     = in_valid && in_ready;
  // Division by zero resolves immediately, so it skips the iterative engine.
  assign div_zero   = ((alu_op == OP_DIVU) || (alu_op == OP_REMU)) && (rs2_data == '0);
  assign iter_start = is_iterative(alu_op) && !div_zero;
  assign shamt      = rs2_data[SHW-1:0];
  assign rs1_s      = rs1_data;
  assign rs2_s      = rs2_data;

  always_comb begin
    sc_result = '0;
    case (alu_op)
      OP_ADD:  sc_result = rs1_data + rs2_data;
      OP_SUB:  sc_result = rs1_data - rs2_data;
      OP_XOR:  sc_result = rs1_data ^ rs2_data;
      OP_OR:   sc_result = rs1_data | rs2_data;
      OP_AND:  sc_result = rs1_data & rs2_data;
      OP_SRL:  sc_result = rs1_data >> shamt;
      OP_SLL:  sc_result = rs1_data << shamt;
      OP_SRA:  sc_result = $unsigned(rs1_s >>> shamt);
      OP_SLT:  sc_result = {{(XLEN-1){1'b0}}, (rs1_s < rs2_s)};
      OP_SLTU: sc_result = {{(XLEN-1){1'b0}}, (rs1_data < rs2_data)};
      OP_DIVU: sc_result = '1;
      OP_REMU: sc_result = rs1_data;
      default: sc_result = '0;
    endcase
  end

  exu_muldiv #(
    .XLEN(XLEN)
  ) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .start (accept && iter_start),
    .op    (alu_op),
    .a     (rs1_data),
    .b     (rs2_data),
    .done  (md_done),
    .result(md_result)
  );

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) state_d = iter_start ? ST_BUSY : ST_DONE;
        ST_BUSY: if (md_done) state_d = ST_DONE;
        ST_DONE: begin
          if (accept)         state_d = iter_start ? ST_BUSY : ST_DONE;
          else if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = !flush && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_BUSY);
  end

  always_comb begin
    alu_out_d = alu_out_q;
    if (accept && !iter_start) alu_out_d = sc_result;
    else if (md_done)          alu_out_d = md_result;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      alu_out_q <= '0;
    end else begin
      state_q   <= state_d;
      alu_out_q <= alu_out_d;
    end
  end

  assign alu_out = alu_out_q;

endmodule

// File: tb/tb_exu_mc.sv
// Directed testbench for exu_mc: ALU ops, iterative mul/div, divide by zero,
// back-pressure, flush and mid-operation reset.
module tb_exu_mc;
  import exu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_out;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  exu_mc #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_op   (alu_op),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .alu_out  (alu_out),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic single(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    alu_op    = op;
    rs1_data  = a;
    rs2_data  = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk1({tag, "_vld"}, out_valid, 1'b1);
    chk1({tag, "_bsy"}, busy, 1'b0);
    chk(tag, alu_out, exp);
  endtask

  task automatic iter(input string tag, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int cyc;
    int bc;
    cyc = 0;
    bc  = 0;
    alu_op    = op;
    rs1_data  = a;
    rs2_data  = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && cyc < 100) begin
      if (busy) bc++;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'd32);
    chk({tag, "_busycyc"}, 32'(bc), 32'd32);
    chk1({tag, "_vld"}, out_valid, 1'b1);
    chk(tag, alu_out, exp);
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_op    = 4'h0;
    rs1_data  = '0;
    rs2_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_vld", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_out", alu_out, 32'h0);
    rst = 1'b1;
    #1;
    chk1("rst_rdy", in_ready, 1'b1);
    @(posedge clk); #1;

    single("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000);
    single("sub_neg", OP_SUB, 32'h0, 32'h1, 32'hFFFF_FFFF);
    single("srl", OP_SRL, 32'h8000_0000, 32'h24, 32'h0800_0000);
    single("sra", OP_SRA, 32'h8000_0000, 32'h24, 32'hF800_0000);
    single("sll", OP_SLL, 32'h8000_0000, 32'h24, 32'h0000_0000);
    single("slt", OP_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1);
    single("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0);
    single("xor", OP_XOR, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB);

    iter("mul", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    iter("mul2", OP_MUL, 32'd1234, 32'd5678, 32'd7006652);
    iter("divu", OP_DIVU, 32'd100, 32'd7, 32'd14);
    iter("remu", OP_REMU, 32'd100, 32'd7, 32'd2);

    single("divu0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
    single("remu0", OP_REMU, 32'd5, 32'd0, 32'd5);
    single("illegal", 4'hF, 32'h1234_5678, 32'h1111_1111, 32'h0);

    // Back-pressure: result held while a new op waits.
    single("bp_seed", OP_ADD, 32'd1, 32'd1, 32'd2);
    out_ready = 1'b0;
    alu_op    = OP_ADD;
    rs1_data  = 32'd10;
    rs2_data  = 32'd20;
    in_valid  = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk1("bp_rdy", in_ready, 1'b0);
      chk1("bp_vld", out_valid, 1'b1);
      chk("bp_hold", alu_out, 32'd2);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk1("bp_release_rdy", in_ready, 1'b1);
    @(posedge clk); #1;
    chk("bp_new", alu_out, 32'd30);
    for (int i = 0; i < 10; i++) begin
      rs1_data = 32'(i);
      rs2_data = 32'd100;
      @(posedge clk); #1;
      chk1("b2b_vld", out_valid, 1'b1);
      chk("b2b_out", alu_out, 32'(i + 100));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk1("b2b_idle", out_valid, 1'b0);

    // Flush during a mul.
    alu_op   = OP_MUL;
    rs1_data = 32'd3;
    rs2_data = 32'd5;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk1("fl_busy1", busy, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    chk1("fl_busy10", busy, 1'b1);
    flush = 1'b1;
    #1;
    chk1("fl_rdy", in_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk1("fl_busy", busy, 1'b0);
    chk1("fl_vld", out_valid, 1'b0);
    chk("fl_stale", alu_out, 32'd109);
    repeat (40) @(posedge clk);
    #1;
    chk1("fl_vld_late", out_valid, 1'b0);
    chk("fl_stale_late", alu_out, 32'd109);
    single("fl_add", OP_ADD, 32'd2, 32'd3, 32'd5);

    // Flush wins over a simultaneous offer.
    alu_op   = OP_ADD;
    rs1_data = 32'd7;
    rs2_data = 32'd8;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk1("fl_prio_vld", out_valid, 1'b0);
    chk("fl_prio_out", alu_out, 32'd5);

    // Reset in the middle of a divide.
    alu_op   = OP_DIVU;
    rs1_data = 32'd100;
    rs2_data = 32'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk1("mr_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk1("mr_vld", out_valid, 1'b0);
    chk1("mr_busy0", busy, 1'b0);
    chk("mr_out", alu_out, 32'h0);
    chk1("mr_rdy", in_ready, 1'b1);
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    chk1("mr_idle", out_valid, 1'b0);
    iter("mr_divu", OP_DIVU, 32'd100, 32'd7, 32'd14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
